// File: rtl/fir_16_tap.sv
// 16-tap FIR for one accelerometer axis: run shifts a sample into the delay line, then one serial MAC per tap.
// Latency: 18 rising edges from the run edge to filter_data updated (1 shift, 16 MAC, 1 write).
// Backpressure: run is ignored while a computation is in flight; busy = run | internal flag.
module fir_16_tap #(
    parameter int TAPS  = 16,
    parameter int ACC_W = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        busy,
    input  logic [15:0] sample_in,
    output logic [15:0] filter_data,
    input  logic [15:0] coeff0,
    input  logic [15:0] coeff1,
    input  logic [15:0] coeff2,
    input  logic [15:0] coeff3,
    input  logic [15:0] coeff4,
    input  logic [15:0] coeff5,
    input  logic [15:0] coeff6,
    input  logic [15:0] coeff7,
    input  logic [15:0] coeff8,
    input  logic [15:0] coeff9,
    input  logic [15:0] coeff10,
    input  logic [15:0] coeff11,
    input  logic [15:0] coeff12,
    input  logic [15:0] coeff13,
    input  logic [15:0] coeff14,
    input  logic [15:0] coeff15
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    logic signed [15:0]      dly [TAPS];
    logic        [15:0]      coeff [TAPS];
    logic signed [ACC_W-1:0] acc;
    logic        [4:0]       idx;
    logic                    active;
    logic                    start;
    logic signed [32:0]      prod;
    logic signed [ACC_W-1:0] shifted;
    logic        [15:0]      sat_val;

    assign coeff[0]  = coeff0;
    assign coeff[1]  = coeff1;
    assign coeff[2]  = coeff2;
    assign coeff[3]  = coeff3;
    assign coeff[4]  = coeff4;
    assign coeff[5]  = coeff5;
    assign coeff[6]  = coeff6;
    assign coeff[7]  = coeff7;
    assign coeff[8]  = coeff8;
    assign coeff[9]  = coeff9;
    assign coeff[10] = coeff10;
    assign coeff[11] = coeff11;
    assign coeff[12] = coeff12;
    assign coeff[13] = coeff13;
    assign coeff[14] = coeff14;
    assign coeff[15] = coeff15;

    assign start = run && !active;
    assign busy  = run || active;

    // Unsigned Q0.16 coefficient becomes a 17-bit positive operand so 0xFFFF is not read as -1.
    assign prod    = dly[idx[3:0]] * $signed({1'b0, coeff[idx[3:0]]});
    assign shifted = acc >>> 16;

    // Clamp the floored result into the signed 16-bit output range.
    always_comb begin
        sat_val = shifted[15:0];
        if (shifted > SAT_MAX) begin
            sat_val = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            sat_val = 16'h8000;
        end
    end

    // Delay line: shift only when a computation is accepted; contents persist otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                dly[k] <= '0;
            end
        end else if (start) begin
            dly[0] <= sample_in;
            for (int k = 1; k < TAPS; k++) begin
                dly[k] <= dly[k-1];
            end
        end
    end

    // Sequencer: clear on start, one tap per edge while idx < 16, then a write edge ends the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            idx    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (idx < 5'(TAPS)) begin
                acc <= acc + {{(ACC_W-33){prod[32]}}, prod};
                idx <= idx + 5'd1;
            end else begin
                active <= 1'b0;
            end
        end
    end

    // Output register: updated only on the write edge, holds between computations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filter_data <= '0;
        end else if (active && idx == 5'(TAPS)) begin
            filter_data <= sat_val;
        end
    end

endmodule

// File: tb/tb_fir_16_tap.sv
// Scoreboard bench for fir_16_tap: directed runs push expected outputs, a monitor checks them.
// Output is recognised by busy falling while rst is low.
module tb_fir_16_tap;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        busy;
    logic [15:0] sample_in = '0;
    logic [15:0] filter_data;
    logic [15:0] coeff [16];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] val;
        string       name;
    } exp_t;
    exp_t exp_q [$];

    int  mdl [16];
    bit  prev_busy = 1'b0;

    always #5 clk = ~clk;

    fir_16_tap dut (
        .clk(clk), .rst(rst), .run(run), .busy(busy),
        .sample_in(sample_in), .filter_data(filter_data),
        .coeff0(coeff[0]),   .coeff1(coeff[1]),   .coeff2(coeff[2]),   .coeff3(coeff[3]),
        .coeff4(coeff[4]),   .coeff5(coeff[5]),   .coeff6(coeff[6]),   .coeff7(coeff[7]),
        .coeff8(coeff[8]),   .coeff9(coeff[9]),   .coeff10(coeff[10]), .coeff11(coeff[11]),
        .coeff12(coeff[12]), .coeff13(coeff[13]), .coeff14(coeff[14]), .coeff15(coeff[15])
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
                     name, $signed(act), act, $signed(req), req);
        end
    endtask

    // Monitor: busy falling outside reset marks a freshly written filter_data.
    always @(negedge clk) begin
        if (!rst && prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %0d, expected no output", $signed(filter_data));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, filter_data, e.val);
            end
        end
        prev_busy = busy;
    end

    function automatic logic [15:0] model_out();
        longint s;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            s += longint'(mdl[k]) * longint'({48'd0, coeff[k]});
        end
        s = s >>> 16;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic set_all(input logic [15:0] c);
        for (int k = 0; k < 16; k++) coeff[k] = c;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 16; k++) mdl[k] = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One accepted run; use_hand selects the hand-computed value, extra_at > 0 re-pulses run mid-computation.
    task automatic do_run(input string name, input logic signed [15:0] s,
                          input bit use_hand, input logic signed [15:0] hand, input int extra_at);
        exp_t e;
        int   cnt;
        @(posedge clk); #1;
        for (int k = 15; k > 0; k--) mdl[k] = mdl[k-1];
        mdl[0] = s;
        e.val  = use_hand ? hand : model_out();
        e.name = name;
        exp_q.push_back(e);
        run = 1'b1;
        sample_in = s;
        @(posedge clk); #1;
        run = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (cnt == extra_at) begin
                run = 1'b1;
                sample_in = 16'sd5000;
            end else begin
                run = 1'b0;
            end
            @(posedge clk); #1;
        end
        run = 1'b0;
        if (use_hand) begin
            tests++;
            if (cnt != 17) begin
                fails++;
                $display("FAIL %s_busy_len: got %0d edges, expected 17", name, cnt);
            end
        end
    endtask

    initial begin
        set_all(16'h0000);
        for (int k = 0; k < 16; k++) mdl[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_data", filter_data, 16'd0);
        rst = 1'b0;

        // Impulse pass-through
        coeff[0] = 16'hFFFF;
        do_run("impulse_pos", 16'sd1000, 1'b1, 16'sd999, 0);
        do_run("impulse_neg", -16'sd1000, 1'b1, -16'sd1000, 0);

        // Moving average from a cleared delay line
        do_reset();
        set_all(16'h1000);
        for (int k = 1; k <= 16; k++) begin
            do_run($sformatf("mavg_%0d", k), 16'sd1600, 1'b1, 16'(100 * k), 0);
        end
        do_run("mavg_drop", 16'sd0, 1'b1, 16'sd1500, 0);

        // Scaling by 1/64 per tap
        set_all(16'h0400);
        for (int k = 1; k <= 15; k++) do_run("scale_fill", 16'sd6400, 1'b0, '0, 0);
        do_run("scale_final", 16'sd6400, 1'b1, 16'sd1600, 0);

        // Half window
        set_all(16'h0000);
        for (int k = 0; k < 8; k++) coeff[k] = 16'h1000;
        for (int k = 1; k <= 15; k++) do_run("half_fill", 16'sd1600, 1'b0, '0, 0);
        do_run("half_final", 16'sd1600, 1'b1, 16'sd800, 0);

        // Saturation both directions
        set_all(16'hFFFF);
        for (int k = 1; k <= 15; k++) do_run("satp_fill", 16'sd30000, 1'b0, '0, 0);
        do_run("sat_pos", 16'sd30000, 1'b1, 16'sd32767, 0);
        for (int k = 1; k <= 15; k++) do_run("satn_fill", -16'sd30000, 1'b0, '0, 0);
        do_run("sat_neg", -16'sd30000, 1'b1, -16'sd32768, 0);

        // Run pulsed mid-computation must be ignored (no shift of 5000 into the line)
        set_all(16'h0000);
        coeff[0] = 16'hFFFF;
        do_run("rerun_ignored", 16'sd1000, 1'b1, 16'sd999, 5);
        coeff[0] = 16'h0000;
        coeff[1] = 16'hFFFF;
        do_run("rerun_no_shift", 16'sd0, 1'b1, 16'sd999, 0);

        // Reset during MAC cycle 8
        set_all(16'h0000);
        coeff[0] = 16'hFFFF;
        @(posedge clk); #1;
        run = 1'b1;
        sample_in = 16'sd2000;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", {15'd0, busy}, 16'd0);
        check("midrst_data", filter_data, 16'd0);
        for (int k = 0; k < 16; k++) mdl[k] = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        do_run("post_rst_impulse", 16'sd1000, 1'b1, 16'sd999, 0);
        set_all(16'h1000);
        do_run("post_rst_cleared", 16'sd0, 1'b1, 16'sd62, 0);

        repeat (4) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_outputs: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
